// File: rtl/ras_nibble_pkg.sv
// Shared types and sizes for the nibble-stream receiver and its output FIFO.
package ras_nibble_pkg;
    localparam int NIB_PER_WORD = 8;
    localparam int WORD_W       = 32;
    localparam int NIB_W        = 4;

    typedef enum logic {
        S_DATA,
        S_CSUM
    } state_t;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/ras_word_fifo2.sv
// Two-entry valid/ready word FIFO; the head entry is stable while it waits for pop.
module ras_word_fifo2
    import ras_nibble_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  fifo_entry_t entry_i,
    output logic        full_o,
    output logic        valid_o,
    input  logic        pop_i,
    output fifo_entry_t head_o
);
    fifo_entry_t mem_q [2];
    logic        wptr_q, rptr_q;
    logic [1:0]  count_q;
    logic        do_push, do_pop;

    assign full_o  = (count_q == 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= entry_i;
                wptr_q        <= ~wptr_q;
            end
            if (do_pop) begin
                rptr_q <= ~rptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/ras_nibble_rx.sv
// Deserializes the 4-bit LeNet result stream into framed 32-bit words.
// Define RAS_NIBBLE_RX_CSUM_EN to expect and verify a trailing checksum word per frame.
module ras_nibble_rx
    import ras_nibble_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ap_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NIB_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done,
    output logic              csum_err,
    output logic [15:0]       frame_cnt
);
    localparam logic [2:0] LAST_NIB  = 3'(NIB_PER_WORD - 1);
    localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_FRAME - 1);

    logic [2:0]              nib_cnt_q, nib_cnt_d;
    logic [WORD_W-NIB_W-1:0] part_q, part_d;
    logic [7:0]              wcnt_q, wcnt_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    frame_done_q, frame_done_d;
    logic                    hs, word_done, push, fifo_full, in_csum;
    logic [WORD_W-1:0]       assembled;
    fifo_entry_t             push_entry, head_entry;

`ifdef RAS_NIBBLE_RX_CSUM_EN
    state_t            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              csum_err_q, csum_err_d;
    assign in_csum  = (state_q == S_CSUM);
    assign csum_err = csum_err_q;
`else
    assign in_csum  = 1'b0;
    assign csum_err = 1'b0;
`endif

    // Ready only looks at registered FIFO fullness, so a same-cycle pop never opens it.
    assign in_ready   = ap_start && ((nib_cnt_q != LAST_NIB) || !fifo_full || in_csum);
    assign hs         = in_valid && in_ready;
    assign word_done  = hs && (nib_cnt_q == LAST_NIB);
    assign assembled  = {in_data, part_q};
    assign push_entry.last = (wcnt_q == LAST_WORD);
    assign push_entry.data = assembled;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign out_data   = head_entry.data;
    assign out_last   = head_entry.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_cnt_q    <= '0;
            part_q       <= '0;
            wcnt_q       <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
`ifdef RAS_NIBBLE_RX_CSUM_EN
            state_q      <= S_DATA;
            acc_q        <= '0;
            csum_err_q   <= 1'b0;
`endif
        end else begin
            nib_cnt_q    <= nib_cnt_d;
            part_q       <= part_d;
            wcnt_q       <= wcnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
`ifdef RAS_NIBBLE_RX_CSUM_EN
            state_q      <= state_d;
            acc_q        <= acc_d;
            csum_err_q   <= csum_err_d;
`endif
        end
    end

    always_comb begin
        nib_cnt_d    = nib_cnt_q;
        part_d       = part_q;
        wcnt_d       = wcnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
`ifdef RAS_NIBBLE_RX_CSUM_EN
        state_d      = state_q;
        acc_d        = acc_q;
        csum_err_d   = 1'b0;
`endif
        if (hs) begin
            nib_cnt_d = (nib_cnt_q == LAST_NIB) ? 3'd0 : nib_cnt_q + 3'd1;
            for (int k = 0; k < NIB_PER_WORD - 1; k++) begin
                if (nib_cnt_q == 3'(k)) begin
                    part_d[k*NIB_W +: NIB_W] = in_data;
                end
            end
        end
        if (word_done) begin
`ifdef RAS_NIBBLE_RX_CSUM_EN
            if (state_q == S_CSUM) begin
                frame_done_d = 1'b1;
                csum_err_d   = (assembled != acc_q);
                frame_cnt_d  = frame_cnt_q + 16'd1;
                acc_d        = '0;
                state_d      = S_DATA;
            end else begin
                acc_d = acc_q + assembled;
`else
            begin
`endif
                push = 1'b1;
                if (wcnt_q == LAST_WORD) begin
                    wcnt_d = '0;
`ifdef RAS_NIBBLE_RX_CSUM_EN
                    state_d = S_CSUM;
`else
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
`endif
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
        end
    end

    ras_word_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (push_entry),
        .full_o  (fifo_full),
        .valid_o (out_valid),
        .pop_i   (out_ready),
        .head_o  (head_entry)
    );
endmodule

// File: tb/tb_ras_nibble_rx.sv
// Self-checking bench for ras_nibble_rx against a frame-level word/checksum model.
module tb_ras_nibble_rx;
    localparam int WPF = 4;
`ifdef RAS_NIBBLE_RX_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, ap_start, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_data;
    logic [31:0] out_data;
    logic        out_last, frame_done, csum_err;
    logic [15:0] frame_cnt;

    int          checks = 0, errors = 0;
    int          doneSeen = 0, errSeen = 0, expDone = 0, expErr = 0;
    logic [15:0] expFrameCnt = 0;
    int          modelWcnt = 0;
    logic [31:0] modelAcc = 0;
    logic [32:0] expQ[$], gotQ[$];
    bit          randReady = 0;

    ras_nibble_rx #(.WORDS_PER_FRAME(WPF)) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_done(frame_done), .csum_err(csum_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Record every word handshake and every pulse, sampled mid-cycle.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (out_valid && out_ready) gotQ.push_back({out_last, out_data});
            if (frame_done) doneSeen++;
            if (csum_err) errSeen++;
        end
    end

    always @(negedge clk) if (randReady) out_ready = ($urandom % 4) != 0;

    task automatic sendNibble(input logic [3:0] n);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = n;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk); #1; waited++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("[TB] FAIL nibble_accept in_ready=%0b required=1 after %0d cycles", in_ready, waited);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int k = 0; k < 8; k++) sendNibble(w[4*k +: 4]);
    endtask

    // Model: a data word is last when it is the WPF-th of its frame.
    task automatic modelPush(input logic [31:0] w);
        expQ.push_back({modelWcnt == WPF - 1, w});
        modelAcc = modelAcc + w;
        if (modelWcnt == WPF - 1) begin
            modelWcnt = 0;
            if (!CSUM) begin expDone++; expFrameCnt++; end
        end else begin
            modelWcnt++;
        end
    endtask

    task automatic putDataWord(input logic [31:0] w);
        sendWord(w);
        modelPush(w);
    endtask

    task automatic sendChecksum(input bit bad);
        if (CSUM) begin
            sendWord(bad ? (modelAcc ^ 32'h1) : modelAcc);
            expDone++;
            expFrameCnt++;
            if (bad) expErr++;
        end
        modelAcc = 0;
    endtask

    task automatic sendFrame(input bit bad);
        for (int i = 0; i < WPF; i++) putDataWord($urandom);
        sendChecksum(bad);
    endtask

    task automatic waitDrain();
        int n = 0;
        randReady = 0;
        out_ready = 1'b1;
        while (gotQ.size() < expQ.size() && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ap_start = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("[TB] FAIL reset_in_ready got=%0b required=0", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_out_valid got=%0b required=0", out_valid); end
        checks++; if (out_data !== 32'h0)  begin errors++; $display("[TB] FAIL reset_out_data got=%h required=0", out_data); end
        checks++; if (out_last !== 1'b0)   begin errors++; $display("[TB] FAIL reset_out_last got=%0b required=0", out_last); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got=%0b required=0", frame_done); end
        checks++; if (csum_err !== 1'b0)   begin errors++; $display("[TB] FAIL reset_csum_err got=%0b required=0", csum_err); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_frame_cnt got=%h required=0", frame_cnt); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ap_start = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) sendNibble(4'(k));
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got=%0b required=0", out_valid); end
        sendNibble(4'h8);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency out_valid=%0b required=1", out_valid); end
        checks++; if (out_data !== 32'h87654321) begin errors++; $display("[TB] FAIL basic_data got=%h required=87654321", out_data); end
        modelPush(32'h87654321);
        for (int i = 1; i < WPF; i++) putDataWord($urandom);
        sendChecksum(1'b0);
        waitDrain();
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL basic_count got=%0d required=%0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL basic_word%0d got=%h required=%h", i, gotQ[i], expQ[i]); end
        end
        gotQ.delete(); expQ.delete();
        checks++; if (doneSeen != expDone)      begin errors++; $display("[TB] FAIL basic_done got=%0d required=%0d", doneSeen, expDone); end
        checks++; if (frame_cnt !== expFrameCnt) begin errors++; $display("[TB] FAIL basic_frame_cnt got=%0d required=%0d", frame_cnt, expFrameCnt); end
    endtask

    task automatic test_checksum();
        bit bads [3] = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            if (f < 2) begin
                putDataWord(32'h00000001); putDataWord(32'hFFFFFFFF);
                putDataWord(32'h00000000); putDataWord(32'h00000000);
            end else begin
                for (int i = 0; i < WPF; i++) putDataWord($urandom);
            end
            sendChecksum(bads[f]);
            checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL csum_done%0d got=%0b required=1", f, frame_done); end
            checks++; if (csum_err !== (CSUM && bads[f])) begin errors++; $display("[TB] FAIL csum_err%0d got=%0b required=%0b", f, csum_err, CSUM && bads[f]); end
        end
        waitDrain();
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL csum_count got=%0d required=%0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL csum_word%0d got=%h required=%h", i, gotQ[i], expQ[i]); end
        end
        gotQ.delete(); expQ.delete();
        checks++; if (errSeen != expErr)        begin errors++; $display("[TB] FAIL csum_err_total got=%0d required=%0d", errSeen, expErr); end
        checks++; if (frame_cnt !== expFrameCnt) begin errors++; $display("[TB] FAIL csum_frame_cnt got=%0d required=%0d", frame_cnt, expFrameCnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        out_ready = 1'b0;
        putDataWord(w[0]);
        putDataWord(w[1]);
        for (int k = 0; k < 7; k++) sendNibble(w[2][4*k +: 4]);
        for (int c = 0; c < 30; c++) begin
            #1;
            if (c == 0 || c == 29) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready c%0d got=%0b required=0", c, in_ready); end
                checks++; if (out_data !== w[0]) begin errors++; $display("[TB] FAIL bp_head c%0d got=%h required=%h", c, out_data, w[0]); end
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        sendNibble(w[2][31:28]);
        modelPush(w[2]);
        putDataWord(w[3]);
        sendChecksum(1'b0);
        waitDrain();
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL bp_count got=%0d required=%0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL bp_word%0d got=%h required=%h", i, gotQ[i], expQ[i]); end
        end
        gotQ.delete(); expQ.delete();
    endtask

    task automatic test_apstart();
        logic [31:0] w;
        w = $urandom;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) sendNibble(w[4*k +: 4]);
        ap_start = 1'b0;
        in_valid = 1'b1;
        in_data  = w[15:12];
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 0 || c == 9) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ap_in_ready c%0d got=%0b required=0", c, in_ready); end
            end
            @(negedge clk);
        end
        ap_start = 1'b1;
        for (int k = 3; k < 8; k++) sendNibble(w[4*k +: 4]);
        modelPush(w);
        for (int i = 1; i < WPF; i++) putDataWord($urandom);
        sendChecksum(1'b0);
        waitDrain();
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL ap_count got=%0d required=%0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL ap_word%0d got=%h required=%h", i, gotQ[i], expQ[i]); end
        end
        gotQ.delete(); expQ.delete();
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b0;
        putDataWord($urandom);
        putDataWord($urandom);
        for (int k = 0; k < 3; k++) sendNibble(4'($urandom));
        ap_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL rst_out_valid got=%0b required=0", out_valid); end
        checks++; if (out_data !== 32'h0)  begin errors++; $display("[TB] FAIL rst_out_data got=%h required=0", out_data); end
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("[TB] FAIL rst_in_ready got=%0b required=0", in_ready); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("[TB] FAIL rst_frame_cnt got=%0d required=0", frame_cnt); end
        expQ.delete(); gotQ.delete();
        modelWcnt = 0; modelAcc = 0; expFrameCnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ap_start = 1'b1;
        out_ready = 1'b1;
        sendFrame(1'b0);
        waitDrain();
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL rst_count got=%0d required=%0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL rst_word%0d got=%h required=%h", i, gotQ[i], expQ[i]); end
        end
        gotQ.delete(); expQ.delete();
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rst_frame_cnt_after got=%0d required=1", frame_cnt); end
        checks++; if (doneSeen != expDone) begin errors++; $display("[TB] FAIL rst_done_total got=%0d required=%0d", doneSeen, expDone); end
    endtask

    task automatic test_random();
        randReady = 1;
        for (int f = 0; f < 5; f++) sendFrame(($urandom % 3) == 0);
        waitDrain();
        checks++; if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL rand_count got=%0d required=%0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL rand_word%0d got=%h required=%h", i, gotQ[i], expQ[i]); end
        end
        gotQ.delete(); expQ.delete();
        checks++; if (doneSeen != expDone)       begin errors++; $display("[TB] FAIL rand_done got=%0d required=%0d", doneSeen, expDone); end
        checks++; if (errSeen != expErr)         begin errors++; $display("[TB] FAIL rand_err got=%0d required=%0d", errSeen, expErr); end
        checks++; if (frame_cnt !== expFrameCnt) begin errors++; $display("[TB] FAIL rand_frame_cnt got=%0d required=%0d", frame_cnt, expFrameCnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_checksum();
        test_backpressure();
        test_apstart();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/ras_nibble_rx.md
# ras_nibble_rx

Downstream consumer of the 4-bit result stream emitted by the LeNet result path (`rasout_*`). It deserializes nibbles into 32-bit result words and frames them into fixed-length result frames. It buffers the words in a 2-entry output FIFO and, optionally, verifies a trailing checksum word. It sits on the receiving FPGA or loopback test harness and presents an AXI-Stream-style 32-bit word stream to the consumer logic.

## Interface

Parameters:
- `WORDS_PER_FRAME`, default 10: number of data words per frame (one per LeNet class score); legal range 1..255.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ap_start` in 1: level enable. While low, `in_ready`=0; all state is held.
- `in_valid` in 1: nibble valid.
- `in_ready` out 1: nibble accepted when `in_valid && in_ready`.
- `in_data` in 4: nibble.
- `out_valid` out 1: word available.
- `out_ready` in 1: consumer accepts word.
- `out_data` out 32: assembled word.
- `out_last` out 1: high with the final data word of a frame.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `csum_err` out 1: one-cycle pulse, coincident with `frame_done`, on checksum mismatch. Tied 0 without the checksum feature.
- `frame_cnt` out 16: completed frames, wraps 0xFFFF→0.

## Operation

- Nibble order is least-significant first: the k-th accepted nibble of a word (k=0..7) lands in bits [4k+3:4k].
- Nibble counter `nib_cnt` (0..7). On the 8th handshake (`nib_cnt`=7) the full word is pushed into the output FIFO and `nib_cnt` returns to 0.
- `in_ready` = `ap_start` && (`nib_cnt`≠7 || FIFO count<2 || state==S_CSUM). FIFO pop in the same cycle does not open `in_ready` (no ready→ready combinational path).
- State machine:
  - S_DATA: counts data words `wcnt` 0..WORDS_PER_FRAME-1. The pushed word carries `last`=(`wcnt`==WORDS_PER_FRAME-1). After the last word, go to S_CSUM if the checksum feature is compiled in, else stay in S_DATA with `wcnt`=0, pulse `frame_done` and increment `frame_cnt`.
  - S_CSUM: assembles 8 nibbles into the checksum word. This word is not pushed to the FIFO. On completion, compare it with the accumulator, pulse `frame_done` (plus `csum_err` if unequal), increment `frame_cnt`, clear the accumulator and return to S_DATA.
- Accumulator: 32-bit sum modulo 2^32 of every data word of the frame, updated on push.
- `ap_start` falling mid-word or mid-frame: partial nibbles, `wcnt` and the accumulator are retained. Reception resumes when `ap_start` rises.
- FIFO: 2 entries of {last, data[31:0]}. `out_valid` = count≠0. The head entry is held stable while `out_valid && !out_ready`. Simultaneous push and pop at count 1 leaves count at 1.

## Timing

- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `frame_done`=0, `csum_err`=0, `frame_cnt`=0. Internally `nib_cnt`=0, `wcnt`=0, accumulator=0, state S_DATA.
- Reset mid-frame clears everything immediately (asynchronous). The partial frame is discarded with no `frame_done`.
- Latency: `out_valid` rises the cycle after the 8th nibble handshake, or later only if the FIFO is non-empty ahead of it.
- Throughput: 1 nibble/cycle sustained while `out_ready`=1; one word per 8 cycles.
- `frame_done` / `csum_err` assert the cycle after the final nibble handshake of the frame. The final nibble is the last data nibble without the checksum feature, or the last checksum nibble with it.
- Backpressure: with FIFO full, `in_ready` drops only at `nib_cnt`=7; earlier nibbles continue to be accepted.

## Configuration

- `RAS_NIBBLE_RX_CSUM_EN` defined: each frame is WORDS_PER_FRAME data words followed by 1 checksum word. S_CSUM and the accumulator exist, and `csum_err` is live.
- Undefined: frames are data-only. S_CSUM and the accumulator are not built, and `csum_err` is constant 0.

## Structure

- Package `ras_nibble_pkg`: `NIB_PER_WORD`=8, `WORD_W`=32, `NIB_W`=4, state enum {S_DATA, S_CSUM}, FIFO entry struct {last, data}.
- Sub-module `ras_word_fifo2`: the 2-entry valid/ready FIFO. Everything else lives in the top level.

## Test plan

- Nibbles 0x1..0x8 streamed continuously, `out_ready`=1 → `out_data`=0x87654321, `out_valid` one cycle after the 8th handshake.
- WORDS_PER_FRAME=2, words 0x00000001, 0xFFFFFFFF, checksum 0x00000000 (CSUM_EN) → `out_last` on the second word, then `frame_done`=1, `csum_err`=0, `frame_cnt`=1.
- Same frame with checksum 0x00000001 → `csum_err`=1 together with `frame_done`. The next frame is received normally with `csum_err`=0.
- `out_ready`=0 for 30 cycles during a 4-word stream → FIFO holds 2 words, `in_ready` drops at `nib_cnt`=7 of word 3, and no words are lost or reordered after release.
- `ap_start` dropped after 3 nibbles for 10 cycles, then raised → word completes correctly from the remaining 5 nibbles.
- `rst_n` pulsed low after 5 words of a 10-word frame → all outputs are at reset values. The next full frame produces `frame_cnt`=1 and correct `out_last` placement.
